// File: rtl/apb_uart_pkg.sv
// Shared types for the APB UART transmit path.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package apb_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..N-1 and flags the last cycle of every bit.
// bit_end_o is registered; bit_end_nxt_o is its next-cycle value for lookahead.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic [DIV_WIDTH-1:0] n_i,
    input  logic                 restart_i,
    output logic                 bit_end_o,
    output logic                 bit_end_nxt_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 end_q, end_d;

    // n_i is the period that applies from the next cycle on, so the flag
    // compares the next count against it.
    always_comb begin
        if (restart_i || end_q) cnt_d = '0;
        else                    cnt_d = cnt_q + DIV_WIDTH'(1);
        end_d = (cnt_d == (n_i - DIV_WIDTH'(1)));
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
            end_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            end_q <= end_d;
        end
    end

    assign bit_end_o     = end_q;
    assign bit_end_nxt_o = end_d;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit framer: start, DATA_BITS LSB-first, optional parity, 1 or 2 stops.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
    import apb_uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DIV_WIDTH = 32
) (
    input  logic                 arst_ni,
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 stop2_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP2_IDX = IDX_W'(1);

    uart_tx_state_e       state_q, state_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 stop2_q, stop2_d;
    logic [DIV_WIDTH-1:0] n_q, n_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

`ifdef UART_TX_PARITY_EN
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 par_bit;
    assign par_bit = (^data_q) ^ par_odd_q;
`else
    logic                 unused_parity_cfg;
    assign unused_parity_cfg = parity_en_i ^ parity_odd_i;
`endif

    logic                 accept;
    logic                 bit_end, bit_end_nxt;
    logic [DIV_WIDTH-1:0] n_eff;

    assign data_ready_o = (state_q == ST_IDLE) && en_i;
    assign accept       = data_ready_o && data_valid_i;
    assign n_eff        = (clk_div_i == '0) ? DIV_WIDTH'(1) : clk_div_i;

    // Counter is held at zero in IDLE so the first START cycle is count 0.
    uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .n_i           (n_d),
        .restart_i     (state_q == ST_IDLE),
        .bit_end_o     (bit_end),
        .bit_end_nxt_o (bit_end_nxt)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        stop2_d   = stop2_q;
        n_d       = n_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    bit_idx_d = '0;
                    data_d    = data_i;
                    stop2_d   = stop2_i;
                    n_d       = n_eff;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = parity_en_i;
                    par_odd_d = parity_odd_i;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                // bit_idx doubles as the stop-bit index for two-stop frames.
                if (bit_end) begin
                    if (stop2_q && (bit_idx_q == '0)) begin
                        bit_idx_d = STOP2_IDX;
                    end else begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_bit;
`endif
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && bit_end_nxt &&
                 (!stop2_d || (bit_idx_d == STOP2_IDX));
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            data_q    <= '0;
            stop2_q   <= 1'b0;
            n_q       <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            stop2_q   <= stop2_d;
            n_q       <= n_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
`endif
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
